// File: rtl/req_pkg.sv
// Shared constants for the request-capture stage in front of the 4-line priority encoder.
// Default line count, default debounce length and the ack-index width helper.
package req_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int DB_CYCLES_DEF = 16;

  // Width of an index that addresses n lines; never collapses below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(N_REQ_DEF);

endpackage

// File: rtl/req_capture_if.sv
// Consumer-side bundle of req_capture: acknowledge/clear controls in, captured state out.
// The consumer (encoder side) is the master; req_capture is the slave.
interface req_capture_if import req_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
) ();

  localparam int IDX_W = idx_w(N_REQ);

  logic             ack;
  logic [IDX_W-1:0] ack_idx;
  logic             clear_miss;
  logic [N_REQ-1:0] level;
  logic [N_REQ-1:0] pending;
  logic             any_pending;
  logic [N_REQ-1:0] miss;

  modport master (
    output ack, ack_idx, clear_miss,
    input  level, pending, any_pending, miss
  );

  modport slave (
    input  ack, ack_idx, clear_miss,
    output level, pending, any_pending, miss
  );

endinterface

// File: rtl/debounce_cell.sv
// One request line: 2-FF synchroniser, agreement-restart debounce counter and debounced level.
// rise is high in the cycle whose clock edge takes level from 0 to 1.
module debounce_cell import req_pkg::*; #(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // The counter only reaches CNT_MAX through an unbroken run of disagreeing samples.
  assign flip = (s != level) && (cnt == CNT_MAX);
  assign rise = flip && !level;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      if (s == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/req_capture.sv
// Synchronises and debounces N_REQ raw request lines, latches each debounced rise as a
// sticky pending bit until acknowledged by index, and flags rises lost on busy lines.
module req_capture import req_pkg::*; #(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] raw_in,
  req_capture_if.slave     bus
);

  localparam int IDX_W = idx_w(N_REQ);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("req_capture: DB_CYCLES must be at least 2");
  end

  logic [N_REQ-1:0] level_w;
  logic [N_REQ-1:0] rise_w;
  logic [N_REQ-1:0] hit;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] miss_q, miss_d;

  for (genvar g = 0; g < N_REQ; g++) begin : g_line
    debounce_cell #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[g]),
      .level (level_w[g]),
      .rise  (rise_w[g])
    );
  end

  // NOTE: every variable written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending_q;
    miss_d    = bus.clear_miss ? '0 : miss_q;
    hit       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // An out-of-range ack_idx matches no line and therefore has no effect.
      hit[i] = bus.ack && (bus.ack_idx == IDX_W'(i));
      if (rise_w[i]) begin
        // A new rise re-arms the line even if it is being acknowledged this cycle;
        // it only counts as lost when the earlier event is still unserviced.
        pending_d[i] = 1'b1;
        if (pending_q[i] && !hit[i]) begin
          miss_d[i] = 1'b1;
        end
      end else if (hit[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      miss_q    <= '0;
    end else begin
      pending_q <= pending_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.level       = level_w;
  assign bus.pending     = pending_q;
  assign bus.any_pending = |pending_q;
  assign bus.miss        = miss_q;

  for (genvar g = 0; g < N_REQ; g++) begin : g_chk
    a_pending_sticky : assert property (@(posedge clk) disable iff (rst)
      pending_q[g] && !hit[g] |=> pending_q[g]);
    a_miss_needs_rise : assert property (@(posedge clk) disable iff (rst)
      !miss_q[g] && !rise_w[g] |=> !miss_q[g]);
  end

endmodule
